// File: rtl/wb_upsizr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_upsizr_pkg
// Description : Shared definitions for the Wishbone narrow-to-wide upsizer:
//               controller state encoding and a ceil(log2) helper usable in
//               constant expressions.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_upsizr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SREQ  = 2'd1,
        ST_SWAIT = 2'd2,
        ST_HACK  = 2'd3
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_upsizr_buf.sv
`default_nettype none
// ============================================================================
// Module      : wb_upsizr_buf
// Description : One-entry read buffer holding a full slave-width word.
//               Provides the hit compare, lane read-out, whole-word fill and
//               byte-enabled merge of a master write into one lane.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               i_clr          - invalidate the entry
//               i_lookup_tag   - tag to compare; o_hit = valid && match
//               i_load*        - fill tag + data, set valid
//               i_merge*       - write sel-enabled bytes into one lane
//               i_rd_lane      - lane selected onto o_rd_dat
// Revision    : 1.0 - initial release
// ============================================================================
module wb_upsizr_buf
    import wb_upsizr_pkg::*;
#(
    parameter  int MARCHBITSZ = 32,
    parameter  int SARCHBITSZ = 128,
    localparam int MADDRBITSZ = MARCHBITSZ - clog2(MARCHBITSZ / 8),
    localparam int LANEBITSZ  = clog2(SARCHBITSZ / MARCHBITSZ),
    localparam int SADDRBITSZ = MADDRBITSZ - LANEBITSZ,
    localparam int LANEW      = (LANEBITSZ > 0) ? LANEBITSZ : 1,
    localparam int NLANES     = SARCHBITSZ / MARCHBITSZ,
    localparam int MSELBITSZ  = MARCHBITSZ / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic [SADDRBITSZ-1:0] i_lookup_tag,
    output logic                  o_hit,
    input  logic                  i_load,
    input  logic [SADDRBITSZ-1:0] i_load_tag,
    input  logic [SARCHBITSZ-1:0] i_load_dat,
    input  logic                  i_merge,
    input  logic [LANEW-1:0]      i_merge_lane,
    input  logic [MSELBITSZ-1:0]  i_merge_sel,
    input  logic [MARCHBITSZ-1:0] i_merge_dat,
    input  logic [LANEW-1:0]      i_rd_lane,
    output logic [MARCHBITSZ-1:0] o_rd_dat
);

    logic                  r_valid;
    logic [SADDRBITSZ-1:0] r_tag;
    logic [SARCHBITSZ-1:0] r_data;

    assign o_hit = r_valid && (r_tag == i_lookup_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_tag   <= i_load_tag;
            r_data  <= i_load_dat;
        end else if (i_merge) begin
            // Keep the buffered copy coherent with the write going to the slave.
            for (int l = 0; l < NLANES; l++) begin
                for (int b = 0; b < MSELBITSZ; b++) begin
                    if ((int'(i_merge_lane) == l) && i_merge_sel[b]) begin
                        r_data[l*MARCHBITSZ + b*8 +: 8] <= i_merge_dat[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        o_rd_dat = '0;
        for (int l = 0; l < NLANES; l++) begin
            if (int'(i_rd_lane) == l) begin
                o_rd_dat = r_data[l*MARCHBITSZ +: MARCHBITSZ];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_upsizr.sv
`default_nettype none
// ============================================================================
// Module      : wb_upsizr
// Description : Wishbone bus upsizer. Bridges a narrow master onto a wide
//               slave, one outstanding request at a time, with a one-word
//               read buffer that answers repeat reads of the same wide word
//               without a slave access.
// Ports       : clk_i, rst_i   - clock, asynchronous active-low reset
//               m_wb_*         - narrow master side (request in, ack/data out)
//               s_wb_*         - wide slave side (request out, ack/data in)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_upsizr
    import wb_upsizr_pkg::*;
#(
    parameter  int MARCHBITSZ = 32,
    parameter  int SARCHBITSZ = 128,
    localparam int MADDRBITSZ = MARCHBITSZ - clog2(MARCHBITSZ / 8),
    localparam int LANEBITSZ  = clog2(SARCHBITSZ / MARCHBITSZ),
    localparam int SADDRBITSZ = MADDRBITSZ - LANEBITSZ,
    localparam int LANEW      = (LANEBITSZ > 0) ? LANEBITSZ : 1,
    localparam int NLANES     = SARCHBITSZ / MARCHBITSZ,
    localparam int MSELBITSZ  = MARCHBITSZ / 8,
    localparam int SSELBITSZ  = SARCHBITSZ / 8
) (
    input  logic                  rst_i,
    input  logic                  clk_i,
    input  logic                  m_wb_cyc_i,
    input  logic                  m_wb_stb_i,
    input  logic                  m_wb_we_i,
    input  logic [MADDRBITSZ-1:0] m_wb_addr_i,
    input  logic [MSELBITSZ-1:0]  m_wb_sel_i,
    input  logic [MARCHBITSZ-1:0] m_wb_dat_i,
    output logic                  m_wb_bsy_o,
    output logic                  m_wb_ack_o,
    output logic [MARCHBITSZ-1:0] m_wb_dat_o,
    output logic                  s_wb_cyc_o,
    output logic                  s_wb_stb_o,
    output logic                  s_wb_we_o,
    output logic [SADDRBITSZ-1:0] s_wb_addr_o,
    output logic [SSELBITSZ-1:0]  s_wb_sel_o,
    output logic [SARCHBITSZ-1:0] s_wb_dat_o,
    input  logic                  s_wb_bsy_i,
    input  logic                  s_wb_ack_i,
    input  logic [SARCHBITSZ-1:0] s_wb_dat_i
);

    state_t                r_state;
    logic                  r_we;
    logic [MADDRBITSZ-1:0] r_addr;
    logic [MSELBITSZ-1:0]  r_sel;
    logic [MARCHBITSZ-1:0] r_dat;

    logic [LANEW-1:0]      w_req_lane;
    logic [LANEW-1:0]      w_in_lane;
    logic [SADDRBITSZ-1:0] w_req_tag;
    logic [SADDRBITSZ-1:0] w_in_tag;
    logic                  w_accept;
    logic                  w_buf_hit;
    logic                  w_buf_clr;
    logic                  w_buf_load;
    logic                  w_buf_merge;
    logic [MARCHBITSZ-1:0] w_buf_lane_dat;
    logic                  w_slv_active;
    logic                  w_slv_ack;
    logic                  w_hit_ack;
    logic [SSELBITSZ-1:0]  w_s_sel;
    logic [SARCHBITSZ-1:0] w_s_dat;
    logic [MARCHBITSZ-1:0] w_s_lane_dat;

    // With equal widths there is no lane field at all; lane is pinned to 0.
    generate
        if (LANEBITSZ > 0) begin : g_lane
            assign w_req_lane = r_addr[LANEBITSZ-1:0];
            assign w_in_lane  = m_wb_addr_i[LANEBITSZ-1:0];
        end else begin : g_nolane
            assign w_req_lane = 1'b0;
            assign w_in_lane  = 1'b0;
        end
    endgenerate

    assign w_req_tag = r_addr[MADDRBITSZ-1:LANEBITSZ];
    assign w_in_tag  = m_wb_addr_i[MADDRBITSZ-1:LANEBITSZ];

    assign w_accept     = m_wb_cyc_i && m_wb_stb_i && (r_state == ST_IDLE);
    assign w_slv_active = (r_state == ST_SREQ) || (r_state == ST_SWAIT);
    // A dropped master cycle suppresses any ack, including a late slave ack.
    assign w_slv_ack    = (r_state == ST_SWAIT) && m_wb_cyc_i && s_wb_ack_i;
    assign w_hit_ack    = (r_state == ST_HACK) && m_wb_cyc_i;

    assign w_buf_clr   = (r_state != ST_IDLE) && !m_wb_cyc_i;
    assign w_buf_load  = w_slv_ack && !r_we;
    assign w_buf_merge = w_accept && m_wb_we_i && w_buf_hit;

    wb_upsizr_buf #(
        .MARCHBITSZ (MARCHBITSZ),
        .SARCHBITSZ (SARCHBITSZ)
    ) u_buf (
        .clk          (clk_i),
        .rst_n        (rst_i),
        .i_clr        (w_buf_clr),
        .i_lookup_tag (w_in_tag),
        .o_hit        (w_buf_hit),
        .i_load       (w_buf_load),
        .i_load_tag   (w_req_tag),
        .i_load_dat   (s_wb_dat_i),
        .i_merge      (w_buf_merge),
        .i_merge_lane (w_in_lane),
        .i_merge_sel  (m_wb_sel_i),
        .i_merge_dat  (m_wb_dat_i),
        .i_rd_lane    (w_req_lane),
        .o_rd_dat     (w_buf_lane_dat)
    );

    // Slave-side byte enables land in the requested lane; write data is
    // replicated so the slave sees it in every lane regardless of sel.
    always_comb begin
        w_s_sel      = '0;
        w_s_dat      = '0;
        w_s_lane_dat = '0;
        for (int l = 0; l < NLANES; l++) begin
            w_s_dat[l*MARCHBITSZ +: MARCHBITSZ] = r_dat;
            if (int'(w_req_lane) == l) begin
                w_s_sel[l*MSELBITSZ +: MSELBITSZ] = r_sel;
                w_s_lane_dat = s_wb_dat_i[l*MARCHBITSZ +: MARCHBITSZ];
            end
        end
    end

    // Outputs decode from the state register, which the async reset clears
    // immediately, so every output drops to 0 as soon as reset asserts.
    assign m_wb_bsy_o  = (r_state != ST_IDLE);
    assign m_wb_ack_o  = w_slv_ack || w_hit_ack;
    assign m_wb_dat_o  = w_hit_ack                ? w_buf_lane_dat :
                         (w_slv_ack && !r_we)     ? w_s_lane_dat   : '0;
    assign s_wb_cyc_o  = w_slv_active;
    assign s_wb_stb_o  = (r_state == ST_SREQ);
    assign s_wb_we_o   = w_slv_active && r_we;
    assign s_wb_addr_o = w_slv_active ? w_req_tag : '0;
    assign s_wb_sel_o  = w_slv_active ? w_s_sel   : '0;
    assign s_wb_dat_o  = w_slv_active ? w_s_dat   : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= m_wb_we_i;
                        r_addr  <= m_wb_addr_i;
                        r_sel   <= m_wb_sel_i;
                        r_dat   <= m_wb_dat_i;
                        r_state <= (!m_wb_we_i && w_buf_hit) ? ST_HACK : ST_SREQ;
                    end
                end
                ST_SREQ: begin
                    if (!m_wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (!s_wb_bsy_i) begin
                        r_state <= ST_SWAIT;
                    end
                end
                ST_SWAIT: begin
                    if (!m_wb_cyc_i || s_wb_ack_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_upsizr.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_upsizr
// Description : Self-checking bench for wb_upsizr (32-bit master, 128-bit
//               slave). Directed vector table, hand-written abort and reset
//               sequences, then randomized traffic against a word-level
//               memory + buffer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_upsizr;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         m_wb_cyc_i, m_wb_stb_i, m_wb_we_i;
    logic [29:0]  m_wb_addr_i;
    logic [3:0]   m_wb_sel_i;
    logic [31:0]  m_wb_dat_i;
    logic         m_wb_bsy_o, m_wb_ack_o;
    logic [31:0]  m_wb_dat_o;
    logic         s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
    logic [27:0]  s_wb_addr_o;
    logic [15:0]  s_wb_sel_o;
    logic [127:0] s_wb_dat_o;
    logic         s_wb_bsy_i, s_wb_ack_i;
    logic [127:0] s_wb_dat_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory contents seen by the master, and whether the
    // bridge is expected to hold a valid copy of some wide word.
    logic         ref_valid;
    logic [27:0]  ref_tag;
    logic [127:0] ref_mem [logic [27:0]];
    // Independent storage behind the slave bus-functional model.
    logic [127:0] slv_mem [logic [27:0]];

    always #5 clk_i = ~clk_i;

    wb_upsizr #(.MARCHBITSZ(32), .SARCHBITSZ(128)) dut (
        .rst_i       (rst_i),
        .clk_i       (clk_i),
        .m_wb_cyc_i  (m_wb_cyc_i),
        .m_wb_stb_i  (m_wb_stb_i),
        .m_wb_we_i   (m_wb_we_i),
        .m_wb_addr_i (m_wb_addr_i),
        .m_wb_sel_i  (m_wb_sel_i),
        .m_wb_dat_i  (m_wb_dat_i),
        .m_wb_bsy_o  (m_wb_bsy_o),
        .m_wb_ack_o  (m_wb_ack_o),
        .m_wb_dat_o  (m_wb_dat_o),
        .s_wb_cyc_o  (s_wb_cyc_o),
        .s_wb_stb_o  (s_wb_stb_o),
        .s_wb_we_o   (s_wb_we_o),
        .s_wb_addr_o (s_wb_addr_o),
        .s_wb_sel_o  (s_wb_sel_o),
        .s_wb_dat_o  (s_wb_dat_o),
        .s_wb_bsy_i  (s_wb_bsy_i),
        .s_wb_ack_i  (s_wb_ack_i),
        .s_wb_dat_i  (s_wb_dat_i)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] init_word(input logic [27:0] a);
        int x;
        x = int'(a);
        return {32'((x*3+1)*32'h9E3779B9), 32'((x*5+2)*32'h85EBCA6B),
                32'((x*7+3)*32'hC2B2AE35), 32'((x*11+4)*32'h27D4EB2F)};
    endfunction

    function automatic logic [127:0] ref_get(input logic [27:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [127:0] slv_get(input logic [27:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [27:0] a, input int lane);
        logic [127:0] w;
        w = ref_get(a);
        return w[lane*32 +: 32];
    endfunction

    function automatic void ref_write(input logic [27:0] a, input int lane,
                                      input logic [3:0] sel, input logic [31:0] dat);
        logic [127:0] w;
        w = ref_get(a);
        for (int b = 0; b < 4; b++) if (sel[b]) w[lane*32 + b*8 +: 8] = dat[b*8 +: 8];
        ref_mem[a] = w;
    endfunction

    function automatic void slv_write(input logic [27:0] a, input logic [15:0] sel,
                                      input logic [127:0] dat);
        logic [127:0] w;
        w = slv_get(a);
        for (int b = 0; b < 16; b++) if (sel[b]) w[b*8 +: 8] = dat[b*8 +: 8];
        slv_mem[a] = w;
    endfunction

    // One complete master transaction with a cycle-accurate slave responder.
    task automatic xfer(input logic we, input logic [29:0] addr, input logic [3:0] sel,
                        input logic [31:0] dat, input int bsy_cyc, input int ack_dly,
                        output logic [31:0] rd, output int stb_cnt, output logic [15:0] ssel);
        logic [27:0]  tag;
        int           lane;
        logic         exp_hit;
        logic [31:0]  exp_rd;
        logic [27:0]  c_addr;
        logic [127:0] c_dat;
        logic         c_we;
        logic         stable, issued, done, leak;
        int           bsy_left, ack_cnt, lat;
        tag      = addr[29:2];
        lane     = int'(addr[1:0]);
        exp_hit  = !we && ref_valid && (ref_tag == tag);
        exp_rd   = ref_rd(tag, lane);
        rd = '0; stb_cnt = 0; ssel = '0; lat = 0;
        c_addr = '0; c_dat = '0; c_we = 1'b0;
        stable = 1'b1; issued = 1'b0; done = 1'b0; leak = 1'b0;
        bsy_left = bsy_cyc; ack_cnt = 0;

        @(posedge clk_i); #1;
        chk("idle_bsy", m_wb_bsy_o, 1'b0);
        chk("idle_scyc", s_wb_cyc_o, 1'b0);
        m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = we;
        m_wb_addr_i = addr; m_wb_sel_i = sel; m_wb_dat_i = dat;

        for (int c = 1; c <= 60 && !done; c++) begin
            @(posedge clk_i); #1;
            m_wb_stb_i = 1'b0; s_wb_ack_i = 1'b0; s_wb_bsy_i = 1'b0; s_wb_dat_i = '0;
            if (s_wb_stb_o) begin
                if (stb_cnt == 0) begin
                    c_addr = s_wb_addr_o; ssel = s_wb_sel_o; c_dat = s_wb_dat_o; c_we = s_wb_we_o;
                end else if (c_addr !== s_wb_addr_o || ssel !== s_wb_sel_o ||
                             c_dat !== s_wb_dat_o || c_we !== s_wb_we_o) begin
                    stable = 1'b0;
                end
                if (!m_wb_bsy_o || !s_wb_cyc_o) stable = 1'b0;
                stb_cnt++;
                if (bsy_left > 0) begin
                    s_wb_bsy_i = 1'b1;
                    bsy_left--;
                end else begin
                    issued  = 1'b1;
                    ack_cnt = ack_dly;
                    if (s_wb_we_o) slv_write(s_wb_addr_o, s_wb_sel_o, s_wb_dat_o);
                end
            end else if (s_wb_cyc_o && issued) begin
                if (ack_cnt == 0) begin
                    s_wb_ack_i = 1'b1;
                    s_wb_dat_i = slv_get(c_addr);
                end else begin
                    ack_cnt--;
                end
            end
            #1;
            if (m_wb_ack_o) begin
                done = 1'b1; lat = c; rd = m_wb_dat_o;
            end else if (m_wb_dat_o !== 32'h0) begin
                leak = 1'b1;
            end
        end
        @(posedge clk_i); #1;
        m_wb_cyc_i = 1'b0; s_wb_ack_i = 1'b0; s_wb_dat_i = '0;

        chk("ack_seen", done, 1'b1);
        chk("dat_zero_no_ack", leak, 1'b0);
        chk("slave_access", (stb_cnt > 0), !exp_hit);
        if (exp_hit) begin
            chk("hit_latency", lat, 1);
        end else begin
            chk("stb_cycles", stb_cnt, bsy_cyc + 1);
            chk("miss_latency", lat, bsy_cyc + ack_dly + 2);
            chk("s_addr", c_addr, tag);
            chk("s_sel", ssel, 16'(sel) << (lane*4));
            chk("s_dat", c_dat, {4{dat}});
            chk("s_we", c_we, we);
            chk("sreq_stable", stable, 1'b1);
        end
        if (!we) chk("m_rdata", rd, exp_rd);

        if (we) begin
            ref_write(tag, lane, sel, dat);
        end else if (!exp_hit) begin
            ref_valid = 1'b1;
            ref_tag   = tag;
        end
    endtask

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          bsy;
        int          exp_stb;
        logic [15:0] exp_ssel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t         vecs [7];
    logic [31:0]  rd;
    int           stb_cnt;
    logic [15:0]  ssel;
    logic [127:0] w2;

    initial begin
        rst_i = 1'b0;
        m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = 1'b0;
        m_wb_addr_i = 30'h5; m_wb_sel_i = 4'hF; m_wb_dat_i = 32'hDEADBEEF;
        s_wb_bsy_i = 1'b0; s_wb_ack_i = 1'b1; s_wb_dat_i = '1;
        ref_valid = 1'b0; ref_tag = '0;
        ref_mem[28'h1] = 128'h44443333_22221111_00000000_FFFFEEEE;
        slv_mem[28'h1] = 128'h44443333_22221111_00000000_FFFFEEEE;
        w2 = init_word(28'h2);

        // Outputs under reset, with active-looking inputs applied.
        #3;
        chk("rst_m_bsy", m_wb_bsy_o, 1'b0);
        chk("rst_m_ack", m_wb_ack_o, 1'b0);
        chk("rst_m_dat", m_wb_dat_o, 32'h0);
        chk("rst_s_ctl", {s_wb_cyc_o, s_wb_stb_o, s_wb_we_o}, 3'b000);
        chk("rst_s_addr_sel", {s_wb_addr_o, s_wb_sel_o}, 44'h0);
        chk("rst_s_dat", s_wb_dat_o, 128'h0);
        repeat (2) @(posedge clk_i);
        #1;
        m_wb_cyc_i = 1'b0; m_wb_stb_i = 1'b0; s_wb_ack_i = 1'b0; s_wb_dat_i = '0;
        rst_i = 1'b1;

        vecs[0] = '{1'b0, 30'h5, 4'hF, 32'h0,        0, 1, 16'h00F0, 32'h00000000};
        vecs[1] = '{1'b0, 30'h6, 4'hF, 32'h0,        0, 0, 16'h0000, 32'h22221111};
        vecs[2] = '{1'b1, 30'h6, 4'h3, 32'hAAAABBBB, 0, 1, 16'h0300, 32'h0};
        vecs[3] = '{1'b0, 30'h6, 4'hF, 32'h0,        0, 0, 16'h0000, 32'h2222BBBB};
        vecs[4] = '{1'b0, 30'h4, 4'hF, 32'h0,        0, 0, 16'h0000, 32'hFFFFEEEE};
        vecs[5] = '{1'b0, 30'h9, 4'hF, 32'h0,        3, 4, 16'h00F0, w2[63:32]};
        vecs[6] = '{1'b0, 30'hB, 4'hF, 32'h0,        0, 0, 16'h0000, w2[127:96]};

        for (int i = 0; i < 7; i++) begin
            xfer(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].dat, vecs[i].bsy, 0,
                 rd, stb_cnt, ssel);
            chk($sformatf("tbl%0d_stb", i), stb_cnt, vecs[i].exp_stb);
            chk($sformatf("tbl%0d_ssel", i), ssel, vecs[i].exp_ssel);
            if (!vecs[i].we) chk($sformatf("tbl%0d_rd", i), rd, vecs[i].exp_rd);
        end

        // Master abandons a write while waiting for the slave ack.
        xfer(1'b0, 30'h5, 4'hF, 32'h0, 0, 0, rd, stb_cnt, ssel);
        @(posedge clk_i); #1;
        m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = 1'b1;
        m_wb_addr_i = 30'h5; m_wb_sel_i = 4'hF; m_wb_dat_i = 32'h12345678;
        @(posedge clk_i); #1;
        m_wb_stb_i = 1'b0;
        chk("abort_sreq_stb", s_wb_stb_o, 1'b1);
        slv_write(s_wb_addr_o, s_wb_sel_o, s_wb_dat_o);
        ref_write(28'h1, 1, 4'hF, 32'h12345678);
        @(posedge clk_i); #1;
        chk("abort_swait", {s_wb_cyc_o, s_wb_stb_o}, 2'b10);
        m_wb_cyc_i = 1'b0;
        #1;
        chk("abort_no_ack", m_wb_ack_o, 1'b0);
        @(posedge clk_i); #1;
        s_wb_ack_i = 1'b1; s_wb_dat_i = slv_get(28'h1);
        #1;
        chk("late_ack_ignored", m_wb_ack_o, 1'b0);
        chk("abort_idle", {m_wb_bsy_o, s_wb_cyc_o}, 2'b00);
        @(posedge clk_i); #1;
        s_wb_ack_i = 1'b0; s_wb_dat_i = '0;
        ref_valid = 1'b0;
        xfer(1'b0, 30'h5, 4'hF, 32'h0, 0, 1, rd, stb_cnt, ssel);
        chk("after_abort_miss", stb_cnt, 1);

        // Reset asserted while waiting for the slave ack.
        @(posedge clk_i); #1;
        m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1; m_wb_we_i = 1'b0;
        m_wb_addr_i = 30'hA; m_wb_sel_i = 4'hF; m_wb_dat_i = 32'h0;
        @(posedge clk_i); #1;
        m_wb_stb_i = 1'b0;
        @(posedge clk_i); #1;
        chk("pre_rst_swait", {s_wb_cyc_o, s_wb_stb_o}, 2'b10);
        s_wb_ack_i = 1'b1; s_wb_dat_i = slv_get(28'h2);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_m", {m_wb_bsy_o, m_wb_ack_o, m_wb_dat_o}, 34'h0);
        chk("mid_rst_s_ctl", {s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_addr_o, s_wb_sel_o}, 47'h0);
        chk("mid_rst_s_dat", s_wb_dat_o, 128'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1;
            chk("post_rst_no_ack", m_wb_ack_o, 1'b0);
        end
        m_wb_cyc_i = 1'b0; s_wb_ack_i = 1'b0; s_wb_dat_i = '0;
        ref_valid = 1'b0;
        xfer(1'b0, 30'h6, 4'hF, 32'h0, 0, 0, rd, stb_cnt, ssel);
        chk("after_rst_miss", stb_cnt, 1);

        // Randomized traffic over a small address window to mix hits and misses.
        for (int i = 0; i < 150; i++) begin
            xfer(($urandom_range(0, 2) == 0), 30'($urandom_range(0, 15)),
                 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 2),
                 $urandom_range(0, 2), rd, stb_cnt, ssel);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
